// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator: issues one fetch at a time to the boot ROM or the icache,
// and queues returned {pc,inst} pairs in a small in-order buffer for decode.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] BOOT_BASE = 32'h0000_1000,
    parameter int unsigned BOOT_SIZE = 8192,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        boot_req_valid,
    output logic [31:0] boot_req_addr,
    input  logic        boot_req_ready,
    input  logic        boot_res_valid,
    input  logic [31:0] boot_res_inst,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_req_ready,
    input  logic        ic_res_valid,
    input  logic [31:0] ic_res_inst,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    input  logic        inst_ready
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_KILL
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   pc_q;
    logic          tgt_boot_q;

    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   buf_inst [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          in_boot;
    logic          req_valid;
    logic          req_fire;
    logic          resp_hit;
    logic [31:0]   resp_inst;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_aligned;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Unsigned offset compare covers both window bounds in one test.
    assign in_boot             = (pc_q - BOOT_BASE) < BOOT_SIZE;
    assign redirect_pc_aligned = redirect_pc & ~32'h0000_0003;

    assign req_valid      = !reset && (state_q == S_REQ) && (count_q < CNT_FULL);
    assign boot_req_valid = req_valid && in_boot;
    assign ic_req_valid   = req_valid && !in_boot;
    assign boot_req_addr  = pc_q;
    assign ic_req_addr    = pc_q;
    assign req_fire       = in_boot ? (boot_req_valid && boot_req_ready)
                                    : (ic_req_valid && ic_req_ready);

    assign resp_hit  = tgt_boot_q ? boot_res_valid : ic_res_valid;
    assign resp_inst = tgt_boot_q ? boot_res_inst : ic_res_inst;

    assign inst_valid = !reset && (count_q != '0);
    assign inst_pc    = buf_pc[rd_ptr_q];
    assign inst       = buf_inst[rd_ptr_q];
    assign pop        = inst_valid && inst_ready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = redirect_valid ? S_KILL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = resp_hit ? S_REQ : S_KILL;
                end else if (resp_hit) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_KILL: begin
                if (resp_hit) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            tgt_boot_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                tgt_boot_q <= in_boot;
            end
            if (redirect_valid) begin
                pc_q <= redirect_pc_aligned;
            end else if (push) begin
                pc_q <= pc_q + 32'd4;
            end
            // Flush wins over push/pop; push is already suppressed on redirect.
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= next_ptr(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= next_ptr(rd_ptr_q);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_pc[wr_ptr_q]   <= pc_q;
            buf_inst[wr_ptr_q] <= resp_inst;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: behavioural boot ROM / icache responders plus
// logs of accepted requests and decoded entries, checked against hand-computed values.
module tb_fetch_pc_gen;

    localparam logic [31:0] BOOT_TAG = 32'hB007_0000;
    localparam logic [31:0] IC_TAG   = 32'h1C00_0000;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        boot_req_valid;
    logic [31:0] boot_req_addr;
    logic        boot_req_ready;
    logic        boot_res_valid;
    logic [31:0] boot_res_inst;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_res_valid;
    logic [31:0] ic_res_inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready;

    int n_checks;
    int n_fail;
    int boot_lat;
    int ic_lat;
    int boot_cnt;
    int ic_cnt;
    logic [31:0] boot_addr_p;
    logic [31:0] ic_addr_p;

    logic [32:0] accept_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_inst_q[$];

    fetch_pc_gen #(
        .RESET_PC (32'h0000_1000),
        .BOOT_BASE(32'h0000_1000),
        .BOOT_SIZE(8192),
        .BUF_DEPTH(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .boot_req_valid(boot_req_valid),
        .boot_req_addr (boot_req_addr),
        .boot_req_ready(boot_req_ready),
        .boot_res_valid(boot_res_valid),
        .boot_res_inst (boot_res_inst),
        .ic_req_valid  (ic_req_valid),
        .ic_req_addr   (ic_req_addr),
        .ic_req_ready  (ic_req_ready),
        .ic_res_valid  (ic_res_valid),
        .ic_res_inst   (ic_res_inst),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .inst_ready    (inst_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Responders and loggers run at negedge+3, after stimulus (negedge+1) has settled.
    // A handshake seen here completes on the next rising edge; the answer is then
    // presented 'lat' cycles after that edge.
    always begin
        @(negedge clock);
        #3;
        boot_res_valid = 1'b0;
        ic_res_valid   = 1'b0;
        if (reset) begin
            boot_cnt = 0;
            ic_cnt   = 0;
        end else begin
            if (boot_cnt > 0) begin
                boot_cnt--;
                if (boot_cnt == 0) begin
                    boot_res_valid = 1'b1;
                    boot_res_inst  = boot_addr_p ^ BOOT_TAG;
                end
            end
            if (ic_cnt > 0) begin
                ic_cnt--;
                if (ic_cnt == 0) begin
                    ic_res_valid = 1'b1;
                    ic_res_inst  = ic_addr_p ^ IC_TAG;
                end
            end
            if (boot_req_valid && boot_req_ready) begin
                boot_cnt    = boot_lat;
                boot_addr_p = boot_req_addr;
                accept_q.push_back({1'b1, boot_req_addr});
            end
            if (ic_req_valid && ic_req_ready) begin
                ic_cnt    = ic_lat;
                ic_addr_p = ic_req_addr;
                accept_q.push_back({1'b0, ic_req_addr});
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                pop_pc_q.push_back(inst_pc);
                pop_inst_q.push_back(inst);
            end
        end
    end

    task automatic clear_logs();
        accept_q.delete();
        pop_pc_q.delete();
        pop_inst_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            #1;
        end
        clear_logs();
        reset = 1'b0;
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? accept_q.size() : pop_pc_q.size();
    endfunction

    task automatic wait_size(input string tag, input int which, input int n);
        int budget;
        budget = 200;
        while (qsize(which) < n && budget > 0) begin
            @(negedge clock);
            #1;
            budget--;
        end
        check(tag, 32'(qsize(which) >= n), 32'd1);
    endtask

    // Redirect in the cycle right after an accept, i.e. while the DUT is in WAIT.
    task automatic redirect_on_accept(input logic [31:0] target);
        int n0;
        n0 = accept_q.size();
        wait_size("redir_accept_wait", 0, n0 + 1);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        clear_logs();
        @(negedge clock);
        #1;
        redirect_valid = 1'b0;
    endtask

    function automatic int count_pc(input logic [31:0] pc);
        int n;
        n = 0;
        foreach (pop_pc_q[i]) if (pop_pc_q[i] == pc) n++;
        return n;
    endfunction

    function automatic int count_ic_accepts();
        int n;
        n = 0;
        foreach (accept_q[i]) if (accept_q[i][32] == 1'b0) n++;
        return n;
    endfunction

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        boot_req_ready = 1'b1;
        ic_req_ready   = 1'b1;
        boot_res_valid = 1'b0;
        boot_res_inst  = '0;
        ic_res_valid   = 1'b0;
        ic_res_inst    = '0;
        inst_ready     = 1'b1;
        boot_lat       = 1;
        ic_lat         = 1;
        boot_cnt       = 0;
        ic_cnt         = 0;
        boot_addr_p    = '0;
        ic_addr_p      = '0;

        // Reset state
        @(negedge clock);
        #1;
        check("rst_boot_req_valid", 32'(boot_req_valid), 32'd0);
        check("rst_ic_req_valid", 32'(ic_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_boot_req_addr", boot_req_addr, 32'h0000_1000);
        check("rst_ic_req_addr", ic_req_addr, 32'h0000_1000);

        // Sequential boot fetch
        do_reset();
        wait_size("t1_pops", 1, 3);
        check("t1_first_addr", accept_q[0][31:0], 32'h0000_1000);
        check("t1_first_is_boot", 32'(accept_q[0][32]), 32'd1);
        check("t1_pc0", pop_pc_q[0], 32'h0000_1000);
        check("t1_pc1", pop_pc_q[1], 32'h0000_1004);
        check("t1_pc2", pop_pc_q[2], 32'h0000_1008);
        check("t1_inst0", pop_inst_q[0], 32'hB007_1000);
        check("t1_no_ic", 32'(count_ic_accepts()), 32'd0);

        // Back-pressure: buffer fills to 2, issue stops, resumes at 0x1008
        inst_ready = 1'b0;
        do_reset();
        repeat (20) begin
            @(negedge clock);
            #1;
        end
        check("t2_accepts", 32'(accept_q.size()), 32'd2);
        check("t2_inst_valid", 32'(inst_valid), 32'd1);
        check("t2_head_pc", inst_pc, 32'h0000_1000);
        check("t2_head_inst", inst, 32'hB007_1000);
        check("t2_boot_req_off", 32'(boot_req_valid), 32'd0);
        check("t2_ic_req_off", 32'(ic_req_valid), 32'd0);
        check("t2_addr_held", boot_req_addr, 32'h0000_1008);
        inst_ready = 1'b1;
        wait_size("t2_resume", 0, 3);
        check("t2_resume_addr", accept_q[2][31:0], 32'h0000_1008);
        wait_size("t2_pops", 1, 3);
        check("t2_pop1", pop_pc_q[1], 32'h0000_1004);
        check("t2_pop2", pop_pc_q[2], 32'h0000_1008);

        // Redirect while waiting on boot 0x1004; ROM answers 3 cycles later
        boot_lat = 4;
        do_reset();
        wait_size("t3_accept_1004", 0, 2);
        check("t3_wait_addr", accept_q[1][31:0], 32'h0000_1004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        @(negedge clock);
        #1;
        redirect_valid = 1'b0;
        wait_size("t3_pops", 1, 3);
        check("t3_ic_addr", accept_q[2][31:0], 32'h8000_0000);
        check("t3_ic_tgt", 32'(accept_q[2][32]), 32'd0);
        check("t3_pop1_pc", pop_pc_q[1], 32'h8000_0000);
        check("t3_pop1_inst", pop_inst_q[1], 32'h9C00_0000);
        check("t3_no_1004", 32'(count_pc(32'h0000_1004)), 32'd0);

        // Redirect (misaligned) in the same cycle as the boot response
        boot_lat = 2;
        do_reset();
        wait_size("t4_accept", 0, 1);
        @(negedge clock);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        @(negedge clock);
        #1;
        redirect_valid = 1'b0;
        wait_size("t4_pops", 1, 1);
        check("t4_ic_addr", accept_q[1][31:0], 32'h8000_0000);
        check("t4_ic_tgt", 32'(accept_q[1][32]), 32'd0);
        check("t4_pop0_pc", pop_pc_q[0], 32'h8000_0000);
        check("t4_no_1000", 32'(count_pc(32'h0000_1000)), 32'd0);

        // Boot window upper boundary
        boot_lat = 1;
        do_reset();
        redirect_on_accept(32'h0000_2FFC);
        wait_size("t5_pops", 1, 2);
        check("t5_acc0_addr", accept_q[0][31:0], 32'h0000_2FFC);
        check("t5_acc0_boot", 32'(accept_q[0][32]), 32'd1);
        check("t5_acc1_addr", accept_q[1][31:0], 32'h0000_3000);
        check("t5_acc1_ic", 32'(accept_q[1][32]), 32'd0);
        check("t5_pop0_inst", pop_inst_q[0], 32'hB007_2FFC);
        check("t5_pop1_inst", pop_inst_q[1], 32'h1C00_3000);

        // PC wrap at top of address space
        do_reset();
        redirect_on_accept(32'hFFFF_FFFC);
        wait_size("t6_accepts", 0, 2);
        check("t6_acc0_addr", accept_q[0][31:0], 32'hFFFF_FFFC);
        check("t6_acc1_addr", accept_q[1][31:0], 32'h0000_0000);
        check("t6_acc1_ic", 32'(accept_q[1][32]), 32'd0);
        wait_size("t6_pops", 1, 1);
        check("t6_pop0_pc", pop_pc_q[0], 32'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
